debounce_edge_sync: RTL and testbench

Input-conditioning stage that sits directly upstream of the D flip-flop stage. It takes a raw, asynchronous, bouncy push-button or switch signal and synchronises it to clk. It debounces the signal with a stability counter and produces three things: a clean level (fed to the flip-flop D input), single-cycle rise/fall pulses, and a wrapping press counter. All outputs are registered and share the flip-flop stage's clock and reset.

---
 rtl/debounce_edge_sync.sv | 143 ++++++++++++++
 tb/tb_debounce_edge_sync.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_edge_sync.sv
// Purpose : synchronise and debounce a raw button input; emit a clean level,
//           one-cycle rise/fall pulses and a wrapping count of accepted presses.
// Latency : SYNC_STAGES + STABLE_CYCLES edges from the first edge that sees a new
//           stable btn_in until btn_level and the matching pulse change.
// Backpressure: none; outputs are free-running registered levels and pulses.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   btn_in       raw asynchronous button input
//   btn_level    debounced level (feeds the downstream flip-flop D input)
//   rise_pulse   one cycle high on the first cycle of btn_level=1
//   fall_pulse   one cycle high on the first cycle of btn_level=0
//   press_count  accepted rising edges, modulo 2^COUNT_W

module debounce_edge_sync #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 8,
    parameter int COUNT_W       = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_in,
    output logic               btn_level,
    output logic               rise_pulse,
    output logic               fall_pulse,
    output logic [COUNT_W-1:0] press_count
);

    // A single-cycle stability window still needs a 1-bit counter.
    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW,
        WAIT_HIGH,
        HIGH,
        WAIT_LOW
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   level_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic [COUNT_W-1:0]     count_nxt;

    // Only the last synchroniser stage is ever looked at by the FSM.
    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], btn_in};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= LOW;
            cnt         <= '0;
            btn_level   <= 1'b0;
            rise_pulse  <= 1'b0;
            fall_pulse  <= 1'b0;
            press_count <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            btn_level   <= level_nxt;
            rise_pulse  <= rise_nxt;
            fall_pulse  <= fall_nxt;
            press_count <= count_nxt;
        end
    end

    // Outputs are computed here and registered above, so each pulse lands on
    // the same cycle as the first cycle of the new btn_level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = btn_level;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        count_nxt = press_count;

        case (state)
            LOW: begin
                level_nxt = 1'b0;
                if (s) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    // Bounce: drop back and restart the window next time.
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                    count_nxt = press_count + COUNT_W'(1);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            HIGH: begin
                level_nxt = 1'b1;
                if (!s) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_nxt = HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = LOW;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = LOW;
                cnt_nxt   = '0;
                level_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_edge_sync.sv
module tb_debounce_edge_sync;

    localparam int S  = 2;
    localparam int ST = 8;
    localparam int CW = 4;
    localparam int LAT = S + ST;

    logic          clk;
    logic          rst;
    logic          btn_in;
    logic          btn_level;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] press_count;

    int total;
    int bad;

    // Reference model: s is btn_in delayed by S edges; a new value is accepted
    // once s has disagreed with the level on ST+1 consecutive edges.
    bit hist[$];
    bit m_level;
    bit m_rise;
    bit m_fall;
    int m_run;
    int m_count;

    debounce_edge_sync #(
        .SYNC_STAGES  (S),
        .STABLE_CYCLES(ST),
        .COUNT_W      (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .press_count(press_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void m_clear();
        hist.delete();
        m_level = 1'b0;
        m_rise  = 1'b0;
        m_fall  = 1'b0;
        m_run   = 0;
        m_count = 0;
    endfunction

    // Advance one rising edge, update the model, then settle #1 past the edge.
    task automatic tick();
        bit sv;
        @(posedge clk);
        if (!rst) begin
            m_clear();
        end else begin
            sv = (hist.size() == S) ? hist[0] : 1'b0;
            hist.push_back(btn_in);
            if (hist.size() > S) void'(hist.pop_front());
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (sv != m_level) begin
                m_run++;
                if (m_run == ST + 1) begin
                    m_level = sv;
                    m_run   = 0;
                    if (sv) begin
                        m_rise  = 1'b1;
                        m_count = (m_count + 1) % (1 << CW);
                    end else begin
                        m_fall = 1'b1;
                    end
                end
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst    = 1'b0;
        btn_in = 1'b1;
        m_clear();
        #2;
        total++;
        if ({btn_level, rise_pulse, fall_pulse, press_count} !== {3'b000, CW'(0)}) begin
            bad++;
            $display("FAIL reset_now: got lvl=%b r=%b f=%b cnt=%0d want all 0",
                     btn_level, rise_pulse, fall_pulse, press_count);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if ({btn_level, rise_pulse, fall_pulse, press_count} !== {3'b000, CW'(0)}) begin
                bad++;
                $display("FAIL reset_hold k=%0d: got lvl=%b r=%b f=%b cnt=%0d want all 0",
                         k, btn_level, rise_pulse, fall_pulse, press_count);
            end
        end
    endtask

    task automatic test_clean_press();
        logic          el, er;
        logic [CW-1:0] ec;
        rst    = 1'b1;
        btn_in = 1'b1;
        for (int k = 0; k <= LAT + 2; k++) begin
            tick();
            el = (k >= LAT);
            er = (k == LAT);
            ec = (k >= LAT) ? CW'(1) : CW'(0);
            total++;
            if ({btn_level, rise_pulse, fall_pulse, press_count} !== {el, er, 1'b0, ec}) begin
                bad++;
                $display("FAIL press edge=%0d: got lvl=%b r=%b f=%b cnt=%0d want lvl=%b r=%b f=0 cnt=%0d",
                         k, btn_level, rise_pulse, fall_pulse, press_count, el, er, ec);
            end
        end
    endtask

    task automatic test_clean_release();
        logic el, ef;
        btn_in = 1'b0;
        for (int k = 0; k <= LAT + 2; k++) begin
            tick();
            el = (k < LAT);
            ef = (k == LAT);
            total++;
            if ({btn_level, rise_pulse, fall_pulse, press_count} !== {el, 1'b0, ef, CW'(1)}) begin
                bad++;
                $display("FAIL release edge=%0d: got lvl=%b r=%b f=%b cnt=%0d want lvl=%b r=0 f=%b cnt=1",
                         k, btn_level, rise_pulse, fall_pulse, press_count, el, ef);
            end
        end
    endtask

    task automatic test_bounce();
        bit pat[$];
        pat = '{1, 1, 0, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1,
                0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        foreach (pat[i]) begin
            btn_in = pat[i];
            tick();
            total++;
            if ({btn_level, rise_pulse, fall_pulse, press_count} !== {3'b000, CW'(1)}) begin
                bad++;
                $display("FAIL bounce i=%0d: got lvl=%b r=%b f=%b cnt=%0d want lvl=0 r=0 f=0 cnt=1",
                         i, btn_level, rise_pulse, fall_pulse, press_count);
            end
        end
    endtask

    task automatic test_async_reset();
        logic          el, er;
        logic [CW-1:0] ec;
        btn_in = 1'b1;
        repeat (6) tick();
        total++;
        if ({btn_level, press_count} !== {1'b0, CW'(1)}) begin
            bad++;
            $display("FAIL async_pre: got lvl=%b cnt=%0d want lvl=0 cnt=1", btn_level, press_count);
        end
        #3;
        rst = 1'b0;
        m_clear();
        #1;
        total++;
        if ({btn_level, rise_pulse, fall_pulse, press_count} !== {3'b000, CW'(0)}) begin
            bad++;
            $display("FAIL async_now: got lvl=%b r=%b f=%b cnt=%0d want all 0",
                     btn_level, rise_pulse, fall_pulse, press_count);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            total++;
            if ({btn_level, rise_pulse, fall_pulse, press_count} !== {3'b000, CW'(0)}) begin
                bad++;
                $display("FAIL async_hold k=%0d: got lvl=%b r=%b f=%b cnt=%0d want all 0",
                         k, btn_level, rise_pulse, fall_pulse, press_count);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k <= LAT + 2; k++) begin
            tick();
            el = (k >= LAT);
            er = (k == LAT);
            ec = (k >= LAT) ? CW'(1) : CW'(0);
            total++;
            if ({btn_level, rise_pulse, fall_pulse, press_count} !== {el, er, 1'b0, ec}) begin
                bad++;
                $display("FAIL async_rel edge=%0d: got lvl=%b r=%b f=%b cnt=%0d want lvl=%b r=%b f=0 cnt=%0d",
                         k, btn_level, rise_pulse, fall_pulse, press_count, el, er, ec);
            end
        end
    endtask

    task automatic test_wrap();
        int rises;
        int falls;
        rises  = 0;
        falls  = 0;
        btn_in = 1'b0;
        rst    = 1'b0;
        m_clear();
        tick();
        rst = 1'b1;
        for (int p = 0; p < 16; p++) begin
            btn_in = 1'b1;
            repeat (LAT + 4) begin
                tick();
                if (fall_pulse) falls++;
                if (rise_pulse) begin
                    rises++;
                    total++;
                    if (press_count !== CW'((p + 1) % 16)) begin
                        bad++;
                        $display("FAIL wrap_count p=%0d: got cnt=%0d want %0d",
                                 p, press_count, (p + 1) % 16);
                    end
                end
            end
            btn_in = 1'b0;
            repeat (LAT + 4) begin
                tick();
                if (rise_pulse) rises++;
                if (fall_pulse) falls++;
            end
        end
        total++;
        if (rises != 16 || falls != 16) begin
            bad++;
            $display("FAIL wrap_pulses: got rises=%0d falls=%0d want 16 and 16", rises, falls);
        end
        total++;
        if (press_count !== CW'(0)) begin
            bad++;
            $display("FAIL wrap_final: got cnt=%0d want 0", press_count);
        end
    endtask

    task automatic test_random();
        int cyc;
        int last_pulse;
        int len;
        bit val;
        cyc        = 0;
        last_pulse = -100;
        val        = 1'b0;
        while (cyc < 1500) begin
            if ($urandom_range(0, 39) == 0) begin
                #3;
                rst = 1'b0;
                m_clear();
                #1;
                total++;
                if ({btn_level, rise_pulse, fall_pulse, press_count} !== {3'b000, CW'(0)}) begin
                    bad++;
                    $display("FAIL rand_rst cyc=%0d: got lvl=%b r=%b f=%b cnt=%0d want all 0",
                             cyc, btn_level, rise_pulse, fall_pulse, press_count);
                end
                tick();
                cyc++;
                @(negedge clk);
                rst        = 1'b1;
                last_pulse = -100;
            end
            val = ~val;
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(ST + S, ST + S + 6)
                                              : $urandom_range(1, ST + 2);
            btn_in = val;
            repeat (len) begin
                tick();
                cyc++;
                total++;
                if ({btn_level, rise_pulse, fall_pulse, press_count} !==
                    {m_level, m_rise, m_fall, CW'(m_count)}) begin
                    bad++;
                    $display("FAIL rand_model cyc=%0d: got lvl=%b r=%b f=%b cnt=%0d want lvl=%b r=%b f=%b cnt=%0d",
                             cyc, btn_level, rise_pulse, fall_pulse, press_count,
                             m_level, m_rise, m_fall, m_count % (1 << CW));
                end
                if (rise_pulse || fall_pulse) begin
                    total++;
                    if ((rise_pulse && fall_pulse) || (cyc - last_pulse < ST + 1)) begin
                        bad++;
                        $display("FAIL rand_spacing cyc=%0d: got r=%b f=%b gap=%0d want single pulse gap>=%0d",
                                 cyc, rise_pulse, fall_pulse, cyc - last_pulse, ST + 1);
                    end
                    last_pulse = cyc;
                end
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b0;
        btn_in = 1'b0;
        m_clear();
        test_reset();
        test_clean_press();
        test_clean_release();
        test_bounce();
        test_async_reset();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
